alu_decode_stage: RTL and testbench

//   Registered, parametrised successor to the combinational ALU-control decoder. Decodes op/cmd/sh/i/s/u

---
 rtl/alu_decode_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
//   Registered ALU-control decode stage between the instruction register and
//   the execute stage. It turns op/cmd/sh/i/s/u/mul into an ALU control code
//   plus reg-write, flag-write and illegal strobes, and carries a tag along.
//   A MUL is held in the stage for MUL_CYCLES cycles so the iterative
//   multiplier downstream has time to finish.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous flush, overrides everything else
//   in_valid/in_ready   upstream handshake
//   in_op..in_tag       instruction fields, sampled only on accept
//   out_valid/out_ready downstream handshake
//   out_alu_control     ALU control code (4-bit codes zero-extended to ALU_W)
//   out_reg_wr          result writes the register file
//   out_flags_wr        result updates NZCV
//   out_illegal         unsupported encoding
//   out_tag             tag registered with the decode
//   busy                MUL wait in progress
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready does not depend on in_valid; out_valid does not depend
// on out_ready. While out_valid is high and out_ready is low, every out_*
// field is held stable.

module alu_decode_stage #(
  parameter int ALU_W      = 4,
  parameter int MUL_CYCLES = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [3:0]       in_cmd,
  input  logic [1:0]       in_sh,
  input  logic             in_i,
  input  logic             in_s,
  input  logic             in_u,
  input  logic             in_mul,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] out_alu_control,
  output logic             out_reg_wr,
  output logic             out_flags_wr,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // ALU control codes
  localparam logic [3:0] C_PASS = 4'd0;
  localparam logic [3:0] C_ADD  = 4'd1;
  localparam logic [3:0] C_SUB  = 4'd2;
  localparam logic [3:0] C_AND  = 4'd3;
  localparam logic [3:0] C_ORR  = 4'd4;
  localparam logic [3:0] C_EOR  = 4'd5;
  localparam logic [3:0] C_RSB  = 4'd6;
  localparam logic [3:0] C_BIC  = 4'd7;
  localparam logic [3:0] C_MVN  = 4'd8;
  localparam logic [3:0] C_LSL  = 4'd9;
  localparam logic [3:0] C_LSR  = 4'd10;
  localparam logic [3:0] C_ASR  = 4'd11;
  localparam logic [3:0] C_ROR  = 4'd12;
  localparam logic [3:0] C_ADC  = 4'd13;
  localparam logic [3:0] C_SBC  = 4'd14;
  localparam logic [3:0] C_MUL  = 4'd15;

  // The wait counter is loaded with MUL_CYCLES-2 and counts down to 0,
  // giving MUL_CYCLES-1 cycles in MULW before FULL.
  localparam int              CNT_W    = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
  localparam int              CNT_INIT = (MUL_CYCLES >= 2) ? (MUL_CYCLES - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_INIT);
  localparam logic             MUL_WAIT = (MUL_CYCLES > 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MULW  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ALU_W-1:0] alu_q;
  logic             reg_wr_q, flags_wr_q, illegal_q;
  logic [TAG_W-1:0] tag_q;

  // Combinational decode of the current input fields
  logic [3:0] dec_code;
  logic       dec_reg_wr, dec_flags_wr, dec_illegal, dec_is_mul;

  always_comb begin
    dec_code     = C_PASS;
    dec_reg_wr   = 1'b0;
    dec_flags_wr = 1'b0;
    dec_illegal  = 1'b0;
    dec_is_mul   = 1'b0;
    unique case (in_op)
      2'b00: begin
        if (in_mul) begin
          // in_mul takes priority over whatever cmd holds
          dec_code     = C_MUL;
          dec_reg_wr   = 1'b1;
          dec_flags_wr = in_s;
          dec_is_mul   = 1'b1;
        end else begin
          dec_reg_wr   = 1'b1;
          dec_flags_wr = in_s;
          unique case (in_cmd)
            4'b0000: dec_code = C_AND;
            4'b0001: dec_code = C_EOR;
            4'b0010: dec_code = C_SUB;
            4'b0011: dec_code = C_RSB;
            4'b0100: dec_code = C_ADD;
            4'b0101: dec_code = C_ADC;
            4'b0110: dec_code = C_SBC;
            4'b0111: begin
              // RSC is not supported by the ALU
              dec_code     = C_PASS;
              dec_reg_wr   = 1'b0;
              dec_flags_wr = 1'b0;
              dec_illegal  = 1'b1;
            end
            // Compare forms: flags only, whatever s says
            4'b1000: begin dec_code = C_AND; dec_reg_wr = 1'b0; dec_flags_wr = 1'b1; end
            4'b1001: begin dec_code = C_EOR; dec_reg_wr = 1'b0; dec_flags_wr = 1'b1; end
            4'b1010: begin dec_code = C_SUB; dec_reg_wr = 1'b0; dec_flags_wr = 1'b1; end
            4'b1011: begin dec_code = C_ADD; dec_reg_wr = 1'b0; dec_flags_wr = 1'b1; end
            4'b1100: dec_code = C_ORR;
            4'b1101: begin
              // MOV: immediate passes straight through, register form shifts
              if (in_i) begin
                dec_code = C_PASS;
              end else begin
                unique case (in_sh)
                  2'b00: dec_code = C_LSL;
                  2'b01: dec_code = C_LSR;
                  2'b10: dec_code = C_ASR;
                  2'b11: dec_code = C_ROR;
                endcase
              end
            end
            4'b1110: dec_code = C_BIC;
            4'b1111: dec_code = C_MVN;
          endcase
        end
      end
      2'b01: dec_code = in_u ? C_ADD : C_SUB;
      2'b10: dec_code = C_ADD;
      2'b11: dec_illegal = 1'b1;
    endcase
  end

  // Handshake
  logic accept, take;
  assign in_ready = (state_q == S_EMPTY) || ((state_q == S_FULL) && out_ready);
  assign accept   = in_valid && in_ready;
  assign take     = accept && !flush;   // a flush discards the same-cycle accept

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_EMPTY;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_EMPTY, S_FULL: begin
          if (take) begin
            if (dec_is_mul && MUL_WAIT) begin
              state_d = S_MULW;
              cnt_d   = CNT_LOAD;
            end else begin
              state_d = S_FULL;
            end
          end else if (state_q == S_FULL && out_ready) begin
            state_d = S_EMPTY;
          end
        end
        S_MULW: begin
          if (cnt_q == '0) begin
            state_d = S_FULL;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = S_EMPTY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result registers load only on a kept accept; they are not cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q      <= '0;
      reg_wr_q   <= 1'b0;
      flags_wr_q <= 1'b0;
      illegal_q  <= 1'b0;
      tag_q      <= '0;
    end else if (take) begin
      alu_q      <= ALU_W'(dec_code);
      reg_wr_q   <= dec_reg_wr;
      flags_wr_q <= dec_flags_wr;
      illegal_q  <= dec_illegal;
      tag_q      <= in_tag;
    end
  end

  assign out_valid       = (state_q == S_FULL);
  assign busy            = (state_q == S_MULW);
  assign out_alu_control = alu_q;
  assign out_reg_wr      = reg_wr_q;
  assign out_flags_wr    = flags_wr_q;
  assign out_illegal     = illegal_q;
  assign out_tag         = tag_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage
//   Bench for alu_decode_stage: directed scenarios followed by random traffic,
//   with a queue-based scoreboard fed by a reference decoder and drained by a
//   monitor. A second instance with MUL_CYCLES=1 covers the short MUL path.

module tb_alu_decode_stage;

  localparam int ALU_W = 4;
  localparam int TAG_W = 4;
  localparam int W     = 3 + ALU_W + TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT (MUL_CYCLES=4) ----------------
  logic             flush, in_valid, in_ready;
  logic [1:0]       in_op, in_sh;
  logic [3:0]       in_cmd;
  logic             in_i, in_s, in_u, in_mul;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [ALU_W-1:0] out_alu_control;
  logic             out_reg_wr, out_flags_wr, out_illegal, busy;
  logic [TAG_W-1:0] out_tag;

  alu_decode_stage #(.ALU_W(ALU_W), .MUL_CYCLES(4), .TAG_W(TAG_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_cmd(in_cmd), .in_sh(in_sh), .in_i(in_i), .in_s(in_s),
    .in_u(in_u), .in_mul(in_mul), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_control(out_alu_control), .out_reg_wr(out_reg_wr),
    .out_flags_wr(out_flags_wr), .out_illegal(out_illegal),
    .out_tag(out_tag), .busy(busy)
  );

  // ---------------- second DUT (MUL_CYCLES=1) ----------------
  logic             m1_flush, m1_in_valid, m1_in_ready;
  logic [1:0]       m1_op, m1_sh;
  logic [3:0]       m1_cmd;
  logic             m1_i, m1_s, m1_u, m1_mul;
  logic [TAG_W-1:0] m1_tag;
  logic             m1_out_valid, m1_out_ready;
  logic [ALU_W-1:0] m1_alu;
  logic             m1_reg_wr, m1_flags_wr, m1_illegal, m1_busy;
  logic [TAG_W-1:0] m1_out_tag;

  alu_decode_stage #(.ALU_W(ALU_W), .MUL_CYCLES(1), .TAG_W(TAG_W)) u_dut_m1 (
    .clk(clk), .rst_n(rst_n), .flush(m1_flush),
    .in_valid(m1_in_valid), .in_ready(m1_in_ready),
    .in_op(m1_op), .in_cmd(m1_cmd), .in_sh(m1_sh), .in_i(m1_i), .in_s(m1_s),
    .in_u(m1_u), .in_mul(m1_mul), .in_tag(m1_tag),
    .out_valid(m1_out_valid), .out_ready(m1_out_ready),
    .out_alu_control(m1_alu), .out_reg_wr(m1_reg_wr),
    .out_flags_wr(m1_flags_wr), .out_illegal(m1_illegal),
    .out_tag(m1_out_tag), .busy(m1_busy)
  );

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // DP opcode table: ALU code per cmd; -1 marks the unsupported RSC slot,
  // -2 marks MOV whose code comes from i/sh.
  int dp_table [16] = '{3, 5, 2, 6, 1, 13, 14, -1, 3, 5, 2, 1, 4, -2, 7, 8};

  // Returns {illegal, flags_wr, reg_wr, code[3:0]}
  function automatic logic [6:0] ref_decode(input logic [1:0] op, input logic [3:0] cmd,
                                            input logic [1:0] sh, input logic i, input logic s,
                                            input logic u, input logic mul);
    int code = 0;
    bit rw = 0, fw = 0, ill = 0;
    if (op == 2'd3) begin
      ill = 1;
    end else if (op == 2'd1) begin
      code = u ? 1 : 2;
    end else if (op == 2'd2) begin
      code = 1;
    end else if (mul) begin
      code = 15; rw = 1; fw = s;
    end else if (dp_table[cmd] == -1) begin
      ill = 1;
    end else if (dp_table[cmd] == -2) begin
      code = i ? 0 : 9 + int'(sh); rw = 1; fw = s;
    end else begin
      code = dp_table[cmd];
      if (cmd >= 4'd8 && cmd <= 4'd11) begin rw = 0; fw = 1; end
      else begin rw = 1; fw = s; end
    end
    return {ill, fw, rw, 4'(code)};
  endfunction

  function automatic logic [W-1:0] expected_now();
    logic [6:0] d;
    d = ref_decode(in_op, in_cmd, in_sh, in_i, in_s, in_u, in_mul);
    return {d[6:4], ALU_W'(d[3:0]), in_tag};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: out_valid with tag 0x%0h but nothing expected at %0t", out_tag, $time);
      end else begin
        chk("out_fields", {out_illegal, out_flags_wr, out_reg_wr, out_alu_control, out_tag}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_fields(input logic [1:0] op, input logic [3:0] cmd, input logic [1:0] sh,
                            input logic i, input logic s, input logic u, input logic mul,
                            input logic [TAG_W-1:0] tag);
    in_op = op; in_cmd = cmd; in_sh = sh; in_i = i; in_s = s; in_u = u; in_mul = mul; in_tag = tag;
  endtask

  task automatic rand_fields();
    set_fields(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), TAG_W'($urandom_range(0, 15)));
  endtask

  // Present one item until accepted (bounded), then drop in_valid.
  task automatic send_one(input logic [1:0] op, input logic [3:0] cmd, input logic [1:0] sh,
                          input logic i, input logic s, input logic u, input logic mul,
                          input logic [TAG_W-1:0] tag);
    bit done = 0;
    set_fields(op, cmd, sh, i, s, u, mul, tag);
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      sample();
      if (in_ready) begin
        exp_q.push_back(expected_now());
        done = 1;
        break;
      end
      tick();
    end
    if (!done) chk("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      sample();
      tick();
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0, 0);
    m1_flush = 1'b0; m1_in_valid = 1'b0; m1_out_ready = 1'b1;
    m1_op = 0; m1_cmd = 0; m1_sh = 0; m1_i = 0; m1_s = 0; m1_u = 0; m1_mul = 0; m1_tag = 0;

    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fields", {out_illegal, out_flags_wr, out_reg_wr, out_alu_control, out_tag}, 0);
    chk("rst_in_ready", in_ready, 1);
    tick(); tick();
    rst_n = 1'b1;

    // ADD with s=1, latency 1
    out_ready = 1'b1;
    set_fields(2'b00, 4'b0100, 2'b00, 0, 1, 0, 0, 4'd5);
    in_valid = 1'b1;
    sample();
    chk("t1_in_ready", in_ready, 1);
    exp_q.push_back(expected_now());
    tick();
    in_valid = 1'b0;
    sample();
    chk("t1_valid_lat1", out_valid, 1);
    tick();
    sample();
    chk("t1_back_empty", out_valid, 0);
    tick();

    // Shifts, PASS, compares, MEM/BR, illegal forms
    send_one(2'b00, 4'b1101, 2'b10, 0, 0, 0, 0, 4'd1);  // ASR
    send_one(2'b00, 4'b1101, 2'b10, 1, 1, 0, 0, 4'd2);  // PASS
    send_one(2'b00, 4'b1010, 2'b00, 0, 0, 0, 0, 4'd3);  // CMP s=0
    send_one(2'b00, 4'b0111, 2'b00, 0, 1, 0, 0, 4'd4);  // RSC illegal
    send_one(2'b11, 4'b0100, 2'b00, 0, 1, 1, 1, 4'd6);  // op=11 illegal
    send_one(2'b01, 4'b0000, 2'b00, 0, 1, 0, 0, 4'd7);  // MEM sub
    send_one(2'b01, 4'b0000, 2'b00, 0, 0, 1, 1, 4'd8);  // MEM add, mul ignored
    send_one(2'b10, 4'b1111, 2'b00, 0, 1, 0, 0, 4'd9);  // BR
    drain();

    // MUL, MUL_CYCLES=4: three busy cycles then valid
    set_fields(2'b00, 4'b0010, 2'b00, 0, 1, 0, 1, 4'd9);
    in_valid = 1'b1;
    sample();
    chk("t3_in_ready", in_ready, 1);
    exp_q.push_back(expected_now());
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("t3_busy", busy, 1);
      chk("t3_in_ready_low", in_ready, 0);
      chk("t3_valid_low", out_valid, 0);
      tick();
    end
    sample();
    chk("t3_valid", out_valid, 1);
    chk("t3_busy_done", busy, 0);
    tick();
    drain();

    // Backpressure: hold A for 3 cycles with B waiting, then no bubble
    out_ready = 1'b0;
    set_fields(2'b00, 4'b1100, 2'b00, 0, 1, 0, 0, 4'd10);
    in_valid = 1'b1;
    sample();
    exp_q.push_back(expected_now());
    tick();
    set_fields(2'b00, 4'b1110, 2'b00, 0, 0, 0, 0, 4'd11);
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("t4_in_ready_low", in_ready, 0);
      chk("t4_valid_held", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    sample();
    chk("t4_in_ready_rel", in_ready, 1);
    exp_q.push_back(expected_now());
    tick();
    in_valid = 1'b0;
    sample();
    chk("t4_no_bubble", out_valid, 1);
    tick();
    drain();

    // Flush during MULW with cnt=1
    set_fields(2'b00, 4'b0000, 2'b00, 0, 0, 0, 1, 4'd3);
    in_valid = 1'b1;
    sample();
    exp_q.push_back(expected_now());
    tick();
    in_valid = 1'b0;
    sample();
    tick();
    flush = 1'b1;
    sample();
    chk("t6_busy_before_flush", busy, 1);
    void'(exp_q.pop_back());
    tick();
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("t6_valid_low", out_valid, 0);
      chk("t6_busy_low", busy, 0);
      tick();
    end
    // Flush with a same-cycle accept: item dropped, old fields kept
    flush = 1'b1;
    set_fields(2'b00, 4'b0100, 2'b00, 0, 1, 0, 0, 4'd7);
    in_valid = 1'b1;
    sample();
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    sample();
    chk("t6_flush_drop", out_valid, 0);
    chk("t6_hold_tag", out_tag, 3);
    chk("t6_hold_code", out_alu_control, 15);
    tick();

    // Asynchronous reset mid-MUL
    set_fields(2'b00, 4'b0000, 2'b00, 0, 1, 0, 1, 4'd6);
    in_valid = 1'b1;
    sample();
    exp_q.push_back(expected_now());
    tick();
    in_valid = 1'b0;
    sample();
    chk("t6_mul_busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_fields", {out_illegal, out_flags_wr, out_reg_wr, out_alu_control, out_tag}, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("t6_no_result", out_valid, 0);
      tick();
    end

    // Random traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      bit acc = 0;
      if (!in_valid) begin
        rand_fields();
        in_valid = ($urandom_range(0, 2) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      sample();
      if (busy) chk("rnd_busy_blocks", in_ready, 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(expected_now());
        acc = 1;
      end
      tick();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    drain();

    // MUL_CYCLES=1: MUL behaves like any other op
    m1_op = 2'b00; m1_mul = 1'b1; m1_s = 1'b0; m1_tag = 4'd10; m1_in_valid = 1'b1;
    sample();
    chk("m1_in_ready", m1_in_ready, 1);
    tick();
    m1_in_valid = 1'b0;
    sample();
    chk("m1_valid_lat1", m1_out_valid, 1);
    chk("m1_busy", m1_busy, 0);
    chk("m1_fields", {m1_illegal, m1_flags_wr, m1_reg_wr, m1_alu, m1_out_tag},
        {3'b001, 4'd15, 4'd10});
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
